// File: rtl/add_seq_wide_pkg.sv
// Shared types and constants for the sliced add/subtract sequencer.
// The package keeps its historical name so existing importers still resolve.
package add_seq_pkg;

    localparam int unsigned SLICE_W = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Subtract runs as A + ~B + 1, so the slice-0 carry is forced high
    function automatic logic eff_carry(input logic op, input logic cin);
        return (op == OP_SUB) ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/add_seq_wide_if.sv
// Request/result handshake bundle for add_seq_wide.
// The master drives requests and consumes results; the slave is the sequencer.
interface add_seq_wide_if
    import add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [SLICE_W*WORDS-1:0]   in_a;
    logic [SLICE_W*WORDS-1:0]   in_b;
    logic                       in_op;
    logic                       in_cin;
    logic                       out_valid;
    logic                       out_ready;
    logic [SLICE_W*WORDS-1:0]   out_sum;
    logic                       out_cout;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/add_seq_wide_adder.sv
// Shared 16-bit ripple slice used by the sequencer; the only arithmetic in the block.
module adder_16_bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {16'b0, i_cin};

endmodule

// File: rtl/add_seq_wide.sv
// WORDS x 16-bit add/subtract, one slice per clock through a single adder_16_bit.
// Result and handshake outputs are registered; only the adder slice sits between flops.
module add_seq_wide
    import add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    add_seq_wide_if.slave   bus
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t r_state;
    state_t w_state_next;

    logic [WORDS-1:0][SLICE_W-1:0] r_a;
    logic [WORDS-1:0][SLICE_W-1:0] r_b;
    logic [WORDS-1:0][SLICE_W-1:0] r_acc;
    logic [WORDS-1:0][SLICE_W-1:0] w_acc_next;
    logic                          r_op;
    logic                          r_carry;
    logic [IDX_W-1:0]              r_idx;

    logic                          r_in_ready;
    logic                          r_out_valid;
    logic [SLICE_W*WORDS-1:0]      r_out_sum;
    logic                          r_out_cout;

    logic [SLICE_W-1:0]            w_a_slice;
    logic [SLICE_W-1:0]            w_b_slice;
    logic [SLICE_W-1:0]            w_sum;
    logic                          w_cout;
    logic                          w_accept;
    logic                          w_last;

    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_last    = (r_state == RUN) && (r_idx == LAST_IDX);
    assign w_a_slice = r_a[r_idx];
    assign w_b_slice = (r_op == OP_SUB) ? ~r_b[r_idx] : r_b[r_idx];

    adder_16_bit u_adder (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_acc_next        = r_acc;
        w_acc_next[r_idx] = w_sum;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_next = RUN;
            RUN:     if (w_last)       w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Slices accumulate in r_acc; the output register only loads on the final
    // slice so a partial result is never visible on out_sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_op        <= OP_ADD;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
            if (w_accept) begin
                r_a     <= bus.in_a;
                r_b     <= bus.in_b;
                r_op    <= bus.in_op;
                r_carry <= eff_carry(bus.in_op, bus.in_cin);
                r_idx   <= '0;
            end
            if (r_state == RUN) begin
                r_acc   <= w_acc_next;
                r_carry <= w_cout;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_out_sum  <= w_acc_next;
                    r_out_cout <= w_cout;
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_cout  = r_out_cout;

endmodule
